// File: rtl/addsub_pkg.sv
// Shared types for the pipelined add/subtract unit.
//   addsub_mode_e  : operation select carried on in_mode
//   addsub_flags_t : status flags travelling alongside each result
// The result vector is width-parametric, so modules pair it with
// addsub_flags_t in a locally declared packed beat struct.
package addsub_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_ADDS = 2'd2,
    MODE_SUBS = 2'd3
  } addsub_mode_e;

  typedef struct packed {
    logic carry;  // carry-out for adds, borrow for subtracts
    logic ovf;    // signed overflow of the unsaturated operation
    logic zero;   // final result is zero
    logic sat;    // saturation clamped the result
  } addsub_flags_t;

  // Subtract modes invert B and inject a carry-in of one.
  function automatic logic is_sub_mode(addsub_mode_e m);
    return (m == MODE_SUB) || (m == MODE_SUBS);
  endfunction

  function automatic logic is_sat_mode(addsub_mode_e m);
    return (m == MODE_ADDS) || (m == MODE_SUBS);
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational add/subtract core built on a single adder.
//   a, b   : operands
//   mode   : addsub_mode_e encoding
//   result : final (possibly saturated) result
//   flags  : carry/borrow, signed overflow, zero, saturation
module addsub_core
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result,
  output addsub_flags_t    flags
);

  addsub_mode_e     m;
  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   raw;
  logic             carry;
  logic             ovf;
  logic             sat;

  always_comb begin
    m      = addsub_mode_e'(mode);
    sub    = is_sub_mode(m);
    b_eff  = b ^ {WIDTH{sub}};
    raw    = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub);
    // For subtraction the adder carry is the inverse of borrow.
    carry  = raw[WIDTH] ^ sub;
    ovf    = (a[WIDTH-1] ~^ b_eff[WIDTH-1]) & (raw[WIDTH-1] ^ a[WIDTH-1]);
    sat    = is_sat_mode(m) & carry;
    result = raw[WIDTH-1:0];
    if (sat) begin
      result = sub ? '0 : '1;
    end
    flags = '{carry: carry, ovf: ovf, zero: (result == '0), sat: sat};
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit with valid/ready on both sides.
//   clk, rst                       : clock, async active-high reset
//   in_valid/in_ready              : operand handshake
//   in_a, in_b, in_mode            : operands and operation
//   out_valid/out_ready            : result handshake
//   out_result, out_carry, out_ovf,
//   out_zero, out_sat              : result and flags from the last stage
// Stage 0 captures the core output; later stages forward it unchanged.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_sat
);

  if (WIDTH < 2) begin : g_bad_width
    $error("addsub_pipe: WIDTH must be at least 2");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("addsub_pipe: STAGES must be in 1..4");
  end

  typedef struct packed {
    logic [WIDTH-1:0] result;
    addsub_flags_t    flags;
  } beat_t;

  logic [WIDTH-1:0] core_result;
  addsub_flags_t    core_flags;
  beat_t            core_beat;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] stage_in_v;
  beat_t             data_q     [STAGES];
  beat_t             stage_in_d [STAGES];
  logic              free;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a      (in_a),
    .b      (in_b),
    .mode   (in_mode),
    .result (core_result),
    .flags  (core_flags)
  );

  assign core_beat = '{result: core_result, flags: core_flags};

  // Ready ripples from the output back: a stage advances when it is
  // valid and the stage after it can load this cycle.
  always_comb begin
    adv  = '0;
    load = '0;
    free = out_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      adv[i]  = v[i] & free;
      load[i] = ~v[i] | adv[i];
      free    = load[i];
    end
  end

  // Source of each stage: the core for stage 0, the previous stage otherwise.
  always_comb begin
    stage_in_v    = '0;
    stage_in_v[0] = in_valid;
    stage_in_d[0] = core_beat;
    for (int i = 1; i < int'(STAGES); i++) begin
      stage_in_v[i] = v[i-1];
      stage_in_d[i] = data_q[i-1];
    end
  end

  // Valid/data chain; data only changes when a valid beat moves in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(STAGES); i++) begin
        if (load[i]) begin
          v[i] <= stage_in_v[i];
          if (stage_in_v[i]) begin
            data_q[i] <= stage_in_d[i];
          end
        end
      end
    end
  end

  assign in_ready   = load[0];
  assign out_valid  = v[STAGES-1];
  assign out_result = data_q[STAGES-1].result;
  assign out_carry  = data_q[STAGES-1].flags.carry;
  assign out_ovf    = data_q[STAGES-1].flags.ovf;
  assign out_zero   = data_q[STAGES-1].flags.zero;
  assign out_sat    = data_q[STAGES-1].flags.sat;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: an 8-bit/2-stage instance for directed
// vectors, stall and reset scenarios, and a 16-bit/4-stage instance
// swept against a reference model with random back-pressure.
module tb_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv8, rdy8, ov8, or8;
  logic [7:0] a8, b8, res8;
  logic [1:0] m8;
  logic       c8, o8, z8, s8;

  logic        iv16, rdy16, ov16, or16;
  logic [15:0] a16, b16, res16;
  logic [1:0]  m16;
  logic        c16, o16, z16, s16;

  addsub_pipe #(.WIDTH(8), .STAGES(2)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(rdy8), .in_a(a8), .in_b(b8), .in_mode(m8),
    .out_valid(ov8), .out_ready(or8), .out_result(res8),
    .out_carry(c8), .out_ovf(o8), .out_zero(z8), .out_sat(s8)
  );

  addsub_pipe #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(rdy16), .in_a(a16), .in_b(b16), .in_mode(m16),
    .out_valid(ov16), .out_ready(or16), .out_result(res16),
    .out_carry(c16), .out_ovf(o16), .out_zero(z16), .out_sat(s16)
  );

  int errors = 0;
  int checks = 0;

  // mode, a, b, expected result, expected {carry, ovf, zero, sat}
  typedef struct packed {
    logic [1:0] m;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;

  vec_t tbl [10] = '{
    '{2'd0, 8'h7F, 8'h01, 8'h80, 4'b0100},
    '{2'd0, 8'hFF, 8'h01, 8'h00, 4'b1010},
    '{2'd1, 8'h00, 8'h01, 8'hFF, 4'b1000},
    '{2'd1, 8'h80, 8'h01, 8'h7F, 4'b0100},
    '{2'd2, 8'hF0, 8'h20, 8'hFF, 4'b1001},
    '{2'd3, 8'h10, 8'h20, 8'h00, 4'b1011},
    '{2'd2, 8'h10, 8'h20, 8'h30, 4'b0000},
    '{2'd3, 8'h20, 8'h10, 8'h10, 4'b0000},
    '{2'd1, 8'h05, 8'h05, 8'h00, 4'b0010},
    '{2'd2, 8'h7F, 8'h01, 8'h80, 4'b0100}
  };

  // Reference: {result, carry, ovf, zero, sat} for the 16-bit unit.
  function automatic logic [19:0] ref16(logic [1:0] m, logic [15:0] a, logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, o, st;
    int          sa, sb, sr;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (m[0] == 1'b0) begin
      s  = {1'b0, a} + {1'b0, b};
      c  = s[16];
      sr = sa + sb;
    end else begin
      s  = {1'b0, a} - {1'b0, b};
      c  = (a < b);
      sr = sa - sb;
    end
    o  = (sr > 32767) || (sr < -32768);
    r  = s[15:0];
    st = 1'b0;
    if (m[1] && c) begin
      st = 1'b1;
      r  = m[0] ? 16'h0000 : 16'hFFFF;
    end
    return {r, c, o, (r == 16'h0000), st};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    iv8 = 1'b1; a8 = 8'h01; b8 = 8'h01; m8 = 2'd0; or8 = 1'b1;
    iv16 = 1'b1; a16 = 16'h0001; b16 = 16'h0001; m16 = 2'd0; or16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ov8, res8, c8, o8, z8, s8} !== 13'b0) begin
      errors++;
      $display("FAIL reset8 got=%h want=0", {ov8, res8, c8, o8, z8, s8});
    end
    checks++;
    if ({ov16, res16, c16, o16, z16, s16} !== 21'b0) begin
      errors++;
      $display("FAIL reset16 got=%h want=0", {ov16, res16, c16, o16, z16, s16});
    end
    iv8 = 1'b0; iv16 = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ov8 !== 1'b0 || ov16 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got=%b%b want=00", ov8, ov16);
    end
  endtask

  task automatic test_arith();
    or8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      iv8 = 1'b1; m8 = tbl[i].m; a8 = tbl[i].a; b8 = tbl[i].b;
      #1;
      checks++;
      if (rdy8 !== 1'b1) begin
        errors++;
        $display("FAIL arith_ready[%0d] got=%b want=1", i, rdy8);
      end
      @(posedge clk); #1;
      iv8 = 1'b0;
      #1;
      checks++;
      if (ov8 !== 1'b0) begin
        errors++;
        $display("FAIL arith_early_valid[%0d] got=%b want=0", i, ov8);
      end
      @(posedge clk); #2;
      checks++;
      if ({ov8, res8, c8, o8, z8, s8} !== {1'b1, tbl[i].r, tbl[i].f}) begin
        errors++;
        $display("FAIL arith[%0d] got v=%b r=%h cozs=%b%b%b%b want v=1 r=%h cozs=%b",
                 i, ov8, res8, c8, o8, z8, s8, tbl[i].r, tbl[i].f);
      end
    end
  endtask

  task automatic test_back_to_back();
    or8 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      iv8 = (k < 4); m8 = 2'd0; a8 = 8'(k + 1); b8 = 8'h10;
      #1;
      if (k < 4) begin
        checks++;
        if (rdy8 !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready[%0d] got=%b want=1", k, rdy8);
        end
      end
      if (k >= 2 && k <= 5) begin
        checks++;
        if (ov8 !== 1'b1 || res8 !== 8'(k - 1 + 16)) begin
          errors++;
          $display("FAIL b2b_out[%0d] got v=%b r=%h want v=1 r=%h", k, ov8, res8, 8'(k - 1 + 16));
        end
      end else begin
        checks++;
        if (ov8 !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle[%0d] got=%b want=0", k, ov8);
        end
      end
    end
    iv8 = 1'b0;
  endtask

  task automatic test_stall();
    int         acc;
    logic [7:0] got[$];
    acc = 0;
    or8 = 1'b0;
    for (int cyc = 0; cyc < 30 && got.size() < 4; cyc++) begin
      @(posedge clk); #1;
      or8 = (cyc >= 5);
      iv8 = (acc < 4); m8 = 2'd0; a8 = 8'(acc + 1); b8 = 8'(acc + 1);
      #1;
      if (cyc == 2) begin
        checks++;
        if (rdy8 !== 1'b0 || acc != 2) begin
          errors++;
          $display("FAIL stall_full got ready=%b accepts=%0d want ready=0 accepts=2", rdy8, acc);
        end
      end
      if (cyc >= 2 && cyc <= 4) begin
        checks++;
        if (ov8 !== 1'b1 || res8 !== 8'h02) begin
          errors++;
          $display("FAIL stall_hold[%0d] got v=%b r=%h want v=1 r=02", cyc, ov8, res8);
        end
      end
      if (ov8 && or8) got.push_back(res8);
      if (iv8 && rdy8) acc++;
    end
    iv8 = 1'b0;
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL stall_count got=%0d want=4", got.size());
    end
    for (int j = 0; j < got.size() && j < 4; j++) begin
      checks++;
      if (got[j] !== 8'(2 * (j + 1))) begin
        errors++;
        $display("FAIL stall_order[%0d] got=%h want=%h", j, got[j], 8'(2 * (j + 1)));
      end
    end
    repeat (2) begin
      @(posedge clk); #2;
      checks++;
      if (ov8 !== 1'b0) begin
        errors++;
        $display("FAIL stall_dup got=%b want=0", ov8);
      end
    end
  endtask

  task automatic test_reset_midflight();
    or8 = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b1; m8 = 2'd0; a8 = 8'h03; b8 = 8'h04;
    @(posedge clk); #1;
    a8 = 8'h05; b8 = 8'h06;
    @(posedge clk); #1;
    iv8 = 1'b0;
    #1;
    checks++;
    if (ov8 !== 1'b1 || res8 !== 8'h07) begin
      errors++;
      $display("FAIL midrst_pre got v=%b r=%h want v=1 r=07", ov8, res8);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ov8, res8, c8, o8, z8, s8} !== 13'b0) begin
      errors++;
      $display("FAIL midrst_async got=%h want=0", {ov8, res8, c8, o8, z8, s8});
    end
    iv8 = 1'b1; a8 = 8'h09; b8 = 8'h09; or8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    iv8 = 1'b0;
    #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      checks++;
      if (ov8 !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale[%0d] got=%b want=0", k, ov8);
      end
    end
    @(posedge clk); #1;
    iv8 = 1'b1; m8 = 2'd0; a8 = 8'h01; b8 = 8'h02;
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (ov8 !== 1'b1 || res8 !== 8'h03) begin
      errors++;
      $display("FAIL midrst_after got v=%b r=%h want v=1 r=03", ov8, res8);
    end
  endtask

  task automatic test_wide_sweep();
    logic [19:0] exp_q[$];
    logic [19:0] exp_v;
    logic [19:0] prev;
    logic        prev_stall;
    int          sent, recv;
    sent = 0; recv = 0; prev = '0; prev_stall = 1'b0;
    for (int cyc = 0; cyc < 4000 && recv < 200; cyc++) begin
      @(posedge clk); #1;
      iv16 = (sent < 200) && ($urandom_range(0, 3) != 0);
      a16  = 16'($urandom);
      b16  = 16'($urandom);
      m16  = 2'($urandom_range(0, 3));
      or16 = ($urandom_range(0, 2) != 0);
      #1;
      if (ov16 && prev_stall) begin
        checks++;
        if ({res16, c16, o16, z16, s16} !== prev) begin
          errors++;
          $display("FAIL wide_stable got=%h want=%h", {res16, c16, o16, z16, s16}, prev);
        end
      end
      if (ov16 && or16) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wide_extra got=%h want=none", {res16, c16, o16, z16, s16});
        end else begin
          exp_v = exp_q.pop_front();
          if ({res16, c16, o16, z16, s16} !== exp_v) begin
            errors++;
            $display("FAIL wide_beat[%0d] got=%h want=%h", recv, {res16, c16, o16, z16, s16}, exp_v);
          end
        end
        recv++;
      end
      prev_stall = ov16 && !or16;
      prev       = {res16, c16, o16, z16, s16};
      if (iv16 && rdy16) begin
        exp_q.push_back(ref16(m16, a16, b16));
        sent++;
      end
    end
    iv16 = 1'b0;
    checks++;
    if (recv != 200 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wide_count got recv=%0d pending=%0d want recv=200 pending=0", recv, exp_q.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_wide_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
